proj_to_affine: RTL
===================

Name: proj_to_affine

Overview:
- Downstream stage of the scalar multiplier in the ed25519 datapath.
- Takes the projective point (X, Y, Z) produced by scalar multiplication and returns canonical affine coordinates x = X·Z⁻¹ mod p and y = Y·Z⁻¹ mod p, with p = 2^255−19.
- Z⁻¹ is computed by Fermat inversion (Z^(p−2)) using one shared bit-serial modular multiplier.
- It is the normalisation step that feeds the 64-bit output serializer.

Parameters:
- None. The field is fixed to p = 2^255−19 and the exponent e = p−2 is a hard constant.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, synchronous, active-high
- i_start  input  1  single-cycle start pulse; operands are sampled in this cycle
- i_x  input  256  projective X, any 256-bit value
- i_y  input  256  projective Y, any 256-bit value
- i_z  input  256  projective Z, any 256-bit value
- o_x  output  256  affine x, canonical, range [0, p)
- o_y  output  256  affine y, canonical, range [0, p)
- o_busy  output  1  high in every non-IDLE state
- o_finished  output  1  one-cycle pulse; o_x and o_y are valid from this cycle onward

Behaviour:
- Reset (i_rst = 1 at a clock edge):
  - State goes to IDLE; o_x = 0, o_y = 0, o_busy = 0, o_finished = 0.
  - Reset asserted mid-operation aborts the operation immediately; nothing partial reaches the outputs.
- States and transitions: IDLE -> NORM -> INV -> MULX -> MULY -> DONE -> IDLE.
- IDLE:
  - i_start = 1 registers i_x, i_y, i_z and moves to NORM.
  - i_start in any other state, including DONE, is ignored.
- NORM (1 cycle):
  - Reduces each operand to [0, p) with up to two conditional subtractions of p. Two suffice because 2^256 = 2p + 38.
- Modular multiplier:
  - MSB-first interleaved form: acc <- 2·acc + (b[i] ? a : 0), then subtract p up to twice so that acc < p.
  - 256 steps, i = 255 down to 0, exactly 256 cycles per product.
  - Multiplies run back-to-back with no idle cycles; operand selection is combinational at the boundary.
  - Internal accumulator is 258 bits wide; no other width growth is allowed.
- INV:
  - r is initialised to Zn (the normalised Z). This covers e[254] = 1.
  - For i = 253 down to 0: r <- r·r, then if e[i] = 1, r <- r·Zn.
  - e bits: all ones except e[4] = 0 and e[2] = 0 (e low byte = 0xEB).
  - Cost: 254 squarings + 252 multiplies = 506 products.
- MULX: o_x-register <- Xn·r (256 cycles).
- MULY: o_y-register <- Yn·r (256 cycles).
- Output holding:
  - o_x and o_y are updated only at the end of MULX and MULY respectively.
  - They hold their value through DONE and IDLE until the next operation overwrites them.
  - During an operation o_x may change before o_y; consumers must wait for o_finished.
- DONE (1 cycle): o_finished = 1, o_busy = 1; next state is IDLE.
- Latency:
  - i_start is sampled in cycle 0.
  - NORM occupies cycle 1.
  - The 508 products occupy cycles 2 through 130049.
  - o_finished = 1 in cycle 130050.
  - Latency is fixed and independent of the data.
- Z ≡ 0 mod p (including Z = p): r becomes 0, so the outputs are x = 0 and y = 0. Latency is unchanged and there is no error flag.
- Back-to-back: a new i_start is accepted in the first IDLE cycle after DONE.

Test Plan:
- X=7, Y=9, Z=1 -> o_x=7, o_y=9; o_finished pulses exactly 130050 cycles after i_start; o_busy is high for cycles 1..130050.
- X=2, Y=4, Z=2 -> o_x=1, o_y=2. Then X=3, Y=0, Z=p−1 -> o_x=p−3, o_y=0.
- X=p+5, Y=2^256−1, Z=1 -> o_x=5, o_y=37 (exercises the double conditional subtraction in NORM).
- Z=0 and, separately, Z=p (any X, Y) -> o_x=0, o_y=0 at the same fixed latency.
- i_start pulsed again at cycles 500 and 130050 (the DONE cycle) -> both ignored, exactly one o_finished. Separately, i_rst asserted at cycle 70000 -> o_x=o_y=0, o_busy=0, no o_finished; a fresh start then completes normally.
- 50 random (X, Y, Z) triples with Z ≠ 0 mod p, including the ed25519 base point scaled by random Z, checked against a software model. Outputs must match and be < p.

Source files
------------

// File: rtl/proj_to_affine.sv
// Projective-to-affine conversion for ed25519: x = X/Z, y = Y/Z mod 2^255-19.
// Z^-1 is computed by Fermat inversion on one shared bit-serial multiplier.
module proj_to_affine (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [255:0] i_x,
  input  logic [255:0] i_y,
  input  logic [255:0] i_z,
  output logic [255:0] o_x,
  output logic [255:0] o_y,
  output logic         o_busy,
  output logic         o_finished
);

  localparam logic [255:0] P     = (256'd1 << 255) - 256'd19;
  localparam logic [257:0] P_EXT = {2'b00, P};

  typedef enum logic [2:0] {IDLE, NORM, INV, MULX, MULY, DONE} state_t;

  state_t       state;
  logic [255:0] xn, yn, zn, r;
  logic [257:0] acc;
  logic [7:0]   cnt;
  logic [7:0]   bit_idx;
  logic         mul_phase;

  logic [255:0] mul_a, mul_b, prod;
  logic [257:0] acc_in, s0, s1, acc_nxt;
  logic         e_bit, last_step;

  // Inputs may be anything up to 2^256-1 = 2p+37, so two subtractions reach [0, p).
  function automatic logic [255:0] reduce_p(input logic [255:0] v);
    logic [255:0] t;
    t = (v >= P) ? v - P : v;
    return (t >= P) ? t - P : t;
  endfunction

  // One MSB-first interleaved step; the accumulator restarts whenever cnt is 255.
  always_comb begin
    mul_a = r;
    mul_b = r;
    case (state)
      INV:     if (mul_phase) mul_b = zn;
      MULX:    mul_a = xn;
      MULY:    mul_a = yn;
      default: ;
    endcase
    acc_in  = (cnt == 8'd255) ? '0 : acc;
    s0      = (acc_in << 1) + (mul_b[cnt] ? {2'b00, mul_a} : 258'd0);
    s1      = (s0 >= P_EXT) ? s0 - P_EXT : s0;
    acc_nxt = (s1 >= P_EXT) ? s1 - P_EXT : s1;
  end

  assign prod      = acc_nxt[255:0];
  assign last_step = (cnt == 8'd0);
  // Exponent p-2 has every bit in 253..0 set except bits 4 and 2.
  assign e_bit     = (bit_idx != 8'd4) && (bit_idx != 8'd2);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_x        <= '0;
      o_y        <= '0;
      o_busy     <= 1'b0;
      o_finished <= 1'b0;
      xn         <= '0;
      yn         <= '0;
      zn         <= '0;
      r          <= '0;
      acc        <= '0;
      cnt        <= 8'd255;
      bit_idx    <= 8'd0;
      mul_phase  <= 1'b0;
    end else begin
      o_finished <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            xn     <= i_x;
            yn     <= i_y;
            zn     <= i_z;
            o_busy <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          xn        <= reduce_p(xn);
          yn        <= reduce_p(yn);
          zn        <= reduce_p(zn);
          r         <= reduce_p(zn);
          bit_idx   <= 8'd253;
          mul_phase <= 1'b0;
          cnt       <= 8'd255;
          state     <= INV;
        end
        // Square-and-multiply: a square per exponent bit, then a multiply by Zn if the bit is set.
        INV: begin
          acc <= acc_nxt;
          cnt <= cnt - 8'd1;
          if (last_step) begin
            r <= prod;
            if (!mul_phase && e_bit) begin
              mul_phase <= 1'b1;
            end else begin
              mul_phase <= 1'b0;
              if (bit_idx == 8'd0) state <= MULX;
              else bit_idx <= bit_idx - 8'd1;
            end
          end
        end
        MULX: begin
          acc <= acc_nxt;
          cnt <= cnt - 8'd1;
          if (last_step) begin
            o_x   <= prod;
            state <= MULY;
          end
        end
        MULY: begin
          acc <= acc_nxt;
          cnt <= cnt - 8'd1;
          if (last_step) begin
            o_y        <= prod;
            o_finished <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
